// File: rtl/spm_seq_if.sv
// rtl/spm_seq_if.sv - control, sample, result and engine signals of the spm_seq sequencer
interface spm_seq_if;
    logic [31:0] cfg_total;
    logic [31:0] cfg_interval;
    logic        start;
    logic        abort;
    logic        busy;
    logic        done;
    logic        err;
    logic [15:0] s_data;
    logic        s_valid;
    logic        s_ready;
    logic [15:0] res_min;
    logic [15:0] res_max;
    logic [15:0] res_index;
    logic        res_last;
    logic        res_valid;
    logic        res_ready;
    logic        eng_enable;
    logic        eng_clr;
    logic [15:0] eng_data_in;
    logic        eng_in_avail;
    logic        eng_in_ready;
    logic        eng_out_avail;
    logic [15:0] eng_data_out;
    logic        eng_out_ready;

    // sequencer side
    modport slave (
        input  cfg_total, cfg_interval, start, abort,
        input  s_data, s_valid, res_ready,
        input  eng_in_ready, eng_data_out, eng_out_ready,
        output busy, done, err, s_ready,
        output res_min, res_max, res_index, res_last, res_valid,
        output eng_enable, eng_clr, eng_data_in, eng_in_avail, eng_out_avail
    );

    // environment side: sample source, result sink and engine
    modport master (
        output cfg_total, cfg_interval, start, abort,
        output s_data, s_valid, res_ready,
        output eng_in_ready, eng_data_out, eng_out_ready,
        input  busy, done, err, s_ready,
        input  res_min, res_max, res_index, res_last, res_valid,
        input  eng_enable, eng_clr, eng_data_in, eng_in_avail, eng_out_avail
    );
endinterface

// File: rtl/spm_seq.sv
// rtl/spm_seq.sv - min/max engine sequencer; optional protocol checks under SPM_SEQ_CHECK_EN
module spm_seq #(
    parameter logic [15:0] SYNC_WORD = 16'hA55A
) (
    input  logic     i_clk,
    input  logic     i_rst,
    spm_seq_if.slave bus
);

    typedef enum logic [3:0] {
        S_IDLE, S_WAKE, S_GAP, S_HSTRB, S_HCHK, S_SWAIT,
        S_STRB, S_CHK, S_R0, S_R1, S_R2, S_OUT
    } state_t;

    state_t      r_state;
    logic [31:0] r_total;
    logic [31:0] r_interval;
    logic [31:0] r_tot_cnt;
    logic [31:0] r_int_cnt;
    logic [2:0]  r_hdr_idx;
    logic        r_busy;
    logic        r_done;
    logic        r_err;
    logic        r_s_ready;
    logic [15:0] r_res_min;
    logic [15:0] r_res_max;
    logic [15:0] r_res_index;
    logic        r_res_last;
    logic        r_res_valid;
    logic        r_eng_clr;
    logic [15:0] r_eng_data_in;
    logic        r_eng_in_avail;
    logic        r_eng_out_avail;

    logic        w_final;
    logic [15:0] w_hdr_next;
    logic        w_proto_fail;

    // a sample closes its interval when it is the last of the run or of the interval
    assign w_final = (r_tot_cnt == r_total - 32'd1) || (r_int_cnt == r_interval - 32'd1);

    // header word that follows the one currently indexed by r_hdr_idx
    always_comb begin
        w_hdr_next = 16'h0000;
        case (r_hdr_idx)
            3'd0:    w_hdr_next = r_total[15:0];
            3'd1:    w_hdr_next = r_total[31:16];
            3'd2:    w_hdr_next = r_interval[15:0];
            3'd3:    w_hdr_next = r_interval[31:16];
            default: w_hdr_next = 16'h0000;
        endcase
    end

`ifdef SPM_SEQ_CHECK_EN
    // engine handshake must match the word/readout being sequenced
    always_comb begin
        w_proto_fail = 1'b0;
        case (r_state)
            S_HCHK:     w_proto_fail = !bus.eng_in_ready;
            S_CHK:      w_proto_fail = w_final ? bus.eng_in_ready : !bus.eng_in_ready;
            S_R1, S_R2: w_proto_fail = !bus.eng_out_ready;
            default:    w_proto_fail = 1'b0;
        endcase
    end
`else
    logic w_unused_ready;
    assign w_unused_ready = bus.eng_in_ready ^ bus.eng_out_ready;
    assign w_proto_fail   = 1'b0;
`endif

    // main sequencer: header, sample metering, result readout and handshake
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state         <= S_IDLE;
            r_total         <= '0;
            r_interval      <= '0;
            r_tot_cnt       <= '0;
            r_int_cnt       <= '0;
            r_hdr_idx       <= '0;
            r_busy          <= 1'b0;
            r_done          <= 1'b0;
            r_err           <= 1'b0;
            r_s_ready       <= 1'b0;
            r_res_min       <= '0;
            r_res_max       <= '0;
            r_res_index     <= '0;
            r_res_last      <= 1'b0;
            r_res_valid     <= 1'b0;
            r_eng_clr       <= 1'b0;
            r_eng_data_in   <= '0;
            r_eng_in_avail  <= 1'b0;
            r_eng_out_avail <= 1'b0;
        end else begin
            r_done    <= 1'b0;
            r_eng_clr <= 1'b0;
            if (bus.abort || w_proto_fail) begin
                // abort outranks everything, including a simultaneous start
                if (w_proto_fail) r_err <= 1'b1;
                r_eng_clr       <= 1'b1;
                r_state         <= S_IDLE;
                r_busy          <= 1'b0;
                r_res_valid     <= 1'b0;
                r_s_ready       <= 1'b0;
                r_eng_in_avail  <= 1'b0;
                r_eng_out_avail <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: if (bus.start) begin
                        if (bus.cfg_total == 32'd0 || bus.cfg_interval == 32'd0) begin
                            r_err <= 1'b1;
                        end else begin
                            r_err          <= 1'b0;
                            r_total        <= bus.cfg_total;
                            r_interval     <= bus.cfg_interval;
                            r_tot_cnt      <= '0;
                            r_int_cnt      <= '0;
                            r_res_index    <= '0;
                            r_hdr_idx      <= '0;
                            r_busy         <= 1'b1;
                            r_eng_in_avail <= 1'b1;
                            r_state        <= S_WAKE;
                        end
                    end
                    S_WAKE: begin
                        r_eng_in_avail <= 1'b0;
                        r_state        <= S_GAP;
                    end
                    S_GAP: begin
                        r_eng_data_in  <= SYNC_WORD;
                        r_eng_in_avail <= 1'b1;
                        r_state        <= S_HSTRB;
                    end
                    S_HSTRB: begin
                        r_eng_in_avail <= 1'b0;
                        r_state        <= S_HCHK;
                    end
                    S_HCHK: begin
                        if (r_hdr_idx == 3'd5) begin
                            r_s_ready <= 1'b1;
                            r_state   <= S_SWAIT;
                        end else begin
                            r_hdr_idx      <= r_hdr_idx + 3'd1;
                            r_eng_data_in  <= w_hdr_next;
                            r_eng_in_avail <= 1'b1;
                            r_state        <= S_HSTRB;
                        end
                    end
                    S_SWAIT: if (bus.s_valid) begin
                        r_eng_data_in  <= bus.s_data;
                        r_eng_in_avail <= 1'b1;
                        r_s_ready      <= 1'b0;
                        r_state        <= S_STRB;
                    end
                    S_STRB: begin
                        r_eng_in_avail <= 1'b0;
                        r_state        <= S_CHK;
                    end
                    S_CHK: begin
                        r_tot_cnt <= r_tot_cnt + 32'd1;
                        if (w_final) begin
                            r_int_cnt       <= '0;
                            r_eng_out_avail <= 1'b1;
                            r_state         <= S_R0;
                        end else begin
                            r_int_cnt <= r_int_cnt + 32'd1;
                            r_s_ready <= 1'b1;
                            r_state   <= S_SWAIT;
                        end
                    end
                    S_R0: r_state <= S_R1;
                    S_R1: begin
                        r_res_min <= bus.eng_data_out;
                        r_state   <= S_R2;
                    end
                    S_R2: begin
                        r_res_max       <= bus.eng_data_out;
                        r_eng_out_avail <= 1'b0;
                        r_res_valid     <= 1'b1;
                        r_res_last      <= (r_tot_cnt == r_total);
                        r_state         <= S_OUT;
                    end
                    S_OUT: if (bus.res_ready) begin
                        r_res_valid <= 1'b0;
                        r_res_index <= r_res_index + 16'd1;
                        if (r_res_last) begin
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= S_IDLE;
                        end else begin
                            r_s_ready <= 1'b1;
                            r_state   <= S_SWAIT;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign bus.busy          = r_busy;
    assign bus.done          = r_done;
    assign bus.err           = r_err;
    assign bus.s_ready       = r_s_ready;
    assign bus.res_min       = r_res_min;
    assign bus.res_max       = r_res_max;
    assign bus.res_index     = r_res_index;
    assign bus.res_last      = r_res_last;
    assign bus.res_valid     = r_res_valid;
    assign bus.eng_enable    = r_busy;
    assign bus.eng_clr       = r_eng_clr;
    assign bus.eng_data_in   = r_eng_data_in;
    assign bus.eng_in_avail  = r_eng_in_avail;
    assign bus.eng_out_avail = r_eng_out_avail;

endmodule

// File: tb/tb_spm_seq.sv
// tb/tb_spm_seq.sv - self-checking bench for spm_seq with behavioural engine, source and sink
module tb_spm_seq;

    typedef struct {
        logic [15:0] mn;
        logic [15:0] mx;
        logic [15:0] idx;
        logic        last;
    } res_t;

    typedef struct {
        int unsigned total;
        int unsigned interval;
        int          exp_n;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    spm_seq_if bus ();
    spm_seq dut (.i_clk(clk), .i_rst(rst), .bus(bus));

    int total_chk = 0;
    int bad_chk   = 0;

    logic [15:0] samp[$];
    logic [15:0] avail_log[$];
    res_t        got[$];
    int          sidx = 0;
    logic        s_take = 1'b0;
    int          cyc = 0;
    int          first_avail = -1;
    int          first_sready = -1;
    int          start_cyc = 0;
    int          clr_pulses = 0;
    int          done_pulses = 0;
    int          viol = 0;
    int          withhold = -1;
    int unsigned cur_interval = 1;

    // engine model state
    logic        prev_avail = 1'b0;
    logic        e_pend = 1'b0;
    int          ecount = 0;
    logic [15:0] e_hdr[6];
    int unsigned e_total = 0;
    int unsigned e_interval = 0;
    int unsigned e_n = 0;
    int unsigned e_int_start = 0;
    logic [15:0] e_min = 0;
    logic [15:0] e_max = 0;
    logic [15:0] rd_min = 0;
    logic [15:0] rd_max = 0;
    int          oc = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total_chk++;
        if (act !== exp) begin
            bad_chk++;
            $display("FAIL %s: got=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // engine, sample source, result sink and protocol monitor, all acting at negedge
    initial begin
        logic [15:0] w;
        bus.s_valid = 1'b0;
        bus.s_data = '0;
        bus.res_ready = 1'b0;
        bus.eng_in_ready = 1'b0;
        bus.eng_out_ready = 1'b0;
        bus.eng_data_out = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (bus.eng_in_avail && prev_avail) viol++;
            if (bus.s_ready && (bus.eng_in_avail || bus.eng_out_avail || bus.res_valid)) viol++;
            prev_avail = bus.eng_in_avail;
            if (bus.eng_clr) clr_pulses++;
            if (bus.done) done_pulses++;
            if (bus.eng_in_avail && first_avail < 0) first_avail = cyc;
            if (bus.s_ready && first_sready < 0) first_sready = cyc;

            bus.eng_in_ready = e_pend;
            e_pend = 1'b0;
            if (!bus.eng_enable) begin
                ecount = 0;
                e_n = 0;
                e_int_start = 0;
            end else if (bus.eng_in_avail) begin
                w = bus.eng_data_in;
                avail_log.push_back(w);
                if (ecount >= 1 && ecount <= 6) begin
                    e_hdr[ecount-1] = w;
                    if (ecount - 1 != withhold) e_pend = 1'b1;
                    if (ecount == 6) begin
                        e_total    = {e_hdr[2], e_hdr[1]};
                        e_interval = {e_hdr[4], e_hdr[3]};
                    end
                end else if (ecount > 6) begin
                    if (e_n == e_int_start) begin
                        e_min = w;
                        e_max = w;
                    end else begin
                        if (w < e_min) e_min = w;
                        if (w > e_max) e_max = w;
                    end
                    e_n++;
                    if (e_n == e_total || e_n - e_int_start == e_interval) begin
                        rd_min = e_min;
                        rd_max = e_max;
                        e_int_start = e_n;
                    end else begin
                        e_pend = 1'b1;
                    end
                end
                ecount++;
            end

            if (bus.eng_out_avail) oc++;
            else oc = 0;
            bus.eng_out_ready = (oc == 2 || oc == 3);
            bus.eng_data_out  = (oc == 2) ? rd_min : (oc == 3) ? rd_max : 16'hBEEF;

            if (s_take) sidx++;
            if (sidx < samp.size()) begin
                bus.s_valid = ($urandom_range(3) != 0);
                bus.s_data  = samp[sidx];
            end else begin
                bus.s_valid = 1'b0;
            end
            s_take = bus.s_valid && bus.s_ready;

            bus.res_ready = ($urandom_range(2) != 0);
            if (bus.res_valid && bus.res_ready)
                got.push_back('{bus.res_min, bus.res_max, bus.res_index, bus.res_last});
        end
    end

    task automatic start_run(input int unsigned total, input int unsigned interval, input int wh);
        got.delete();
        avail_log.delete();
        sidx = 0;
        s_take = 1'b0;
        first_avail = -1;
        first_sready = -1;
        withhold = wh;
        cur_interval = interval;
        bus.cfg_total = total;
        bus.cfg_interval = interval;
        bus.start = 1'b1;
        start_cyc = cyc;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (bus.busy && n < budget) begin
            tick();
            n++;
        end
        chk("run_timeout_busy", 64'(bus.busy), 64'd0);
        tick();
    endtask

    // expected results straight from the interval rule over the sample list
    task automatic check_results(input int exp_n);
        int unsigned t;
        int unsigned s;
        int unsigned e;
        int k;
        logic [15:0] mn;
        logic [15:0] mx;
        t = samp.size();
        k = 0;
        chk("n_results", 64'(got.size()), 64'(exp_n));
        for (s = 0; s < t; s = s + cur_interval) begin
            e = (s + cur_interval < t) ? s + cur_interval : t;
            mn = samp[s];
            mx = samp[s];
            for (int unsigned j = s; j < e; j++) begin
                if (samp[j] < mn) mn = samp[j];
                if (samp[j] > mx) mx = samp[j];
            end
            if (k < got.size()) begin
                chk("res_min", 64'(got[k].mn), 64'(mn));
                chk("res_max", 64'(got[k].mx), 64'(mx));
                chk("res_index", 64'(got[k].idx), 64'(k));
                chk("res_last", 64'(got[k].last), 64'(e == t));
            end
            k++;
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vecs[8];
        logic [15:0] exp_hdr[6];
        int          d0;
        int          c0;
        int          n;

        vecs[0] = '{4, 2, 2};
        vecs[1] = '{5, 2, 3};
        vecs[2] = '{1, 1, 1};
        vecs[3] = '{7, 3, 3};
        vecs[4] = '{6, 6, 1};
        vecs[5] = '{3, 5, 1};
        vecs[6] = '{9, 1, 9};
        vecs[7] = '{8, 4, 2};
        exp_hdr[0] = 16'hA55A;
        exp_hdr[1] = 16'h0004;
        exp_hdr[2] = 16'h0000;
        exp_hdr[3] = 16'h0002;
        exp_hdr[4] = 16'h0000;
        exp_hdr[5] = 16'h0000;

        bus.cfg_total = '0;
        bus.cfg_interval = '0;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        chk("reset_flags", 64'({bus.busy, bus.done, bus.err, bus.s_ready, bus.res_valid, bus.res_last,
                                bus.eng_enable, bus.eng_clr, bus.eng_in_avail, bus.eng_out_avail}), 64'd0);
        chk("reset_data", {bus.res_min, bus.res_max, bus.res_index, bus.eng_data_in}, 64'd0);

        // directed 4/2 run: header content and timing, two results
        samp = '{16'h0010, 16'h0020, 16'h0020, 16'h0010};
        d0 = done_pulses;
        start_run(4, 2, -1);
        chk("busy_after_start", 64'(bus.busy), 64'd1);
        wait_idle(400);
        chk("wake_latency", 64'(first_avail - start_cyc), 64'd2);
        chk("header_cycles", 64'(first_sready - first_avail), 64'd14);
        chk("strobe_count", 64'(avail_log.size()), 64'd11);
        if (avail_log.size() >= 7)
            for (int i = 0; i < 6; i++) chk($sformatf("hdr_word%0d", i), 64'(avail_log[i+1]), 64'(exp_hdr[i]));
        check_results(2);
        chk("done_pulse", 64'(done_pulses - d0), 64'd1);
        chk("err_clear", 64'(bus.err), 64'd0);

        // 5/2 run: short last interval
        samp = '{16'h0300, 16'h0100, 16'h0005, 16'hFFFF, 16'h0042};
        start_run(5, 2, -1);
        wait_idle(400);
        check_results(3);

        // zero configuration is rejected
        start_run(0, 5, -1);
        chk("zero_total_err", 64'(bus.err), 64'd1);
        chk("zero_total_busy", 64'(bus.busy), 64'd0);
        repeat (4) tick();
        chk("zero_total_no_avail", 64'(avail_log.size()), 64'd0);
        start_run(3, 0, -1);
        chk("zero_interval_err", 64'(bus.err), 64'd1);
        chk("zero_interval_busy", 64'(bus.busy), 64'd0);

        // table of random-sample runs
        for (int v = 0; v < 8; v++) begin
            samp.delete();
            for (int i = 0; i < int'(vecs[v].total); i++) samp.push_back(16'($urandom));
            d0 = done_pulses;
            start_run(vecs[v].total, vecs[v].interval, -1);
            chk("err_cleared_by_start", 64'(bus.err), 64'd0);
            wait_idle(100 + 30 * int'(vecs[v].total));
            check_results(vecs[v].exp_n);
            chk("done_pulse_v", 64'(done_pulses - d0), 64'd1);
        end

        // abort during the second sample, with wide config to exercise upper header halves
        samp.delete();
        for (int i = 0; i < 10; i++) samp.push_back(16'($urandom));
        c0 = clr_pulses;
        start_run(32'h0002_0003, 32'h0001_0005, -1);
        n = 0;
        while (avail_log.size() < 9 && n < 300) begin
            tick();
            n++;
        end
        chk("abort_reached_sample2", 64'(avail_log.size() >= 9), 64'd1);
        if (avail_log.size() >= 7) begin
            chk("hdr_total_lo", 64'(avail_log[2]), 64'h0003);
            chk("hdr_total_hi", 64'(avail_log[3]), 64'h0002);
            chk("hdr_int_lo", 64'(avail_log[4]), 64'h0005);
            chk("hdr_int_hi", 64'(avail_log[5]), 64'h0001);
        end
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        chk("abort_clr", 64'(bus.eng_clr), 64'd1);
        chk("abort_state", 64'({bus.busy, bus.s_ready, bus.res_valid, bus.eng_enable}), 64'd0);
        tick();
        chk("abort_clr_one_cycle", 64'(bus.eng_clr), 64'd0);
        chk("abort_clr_count", 64'(clr_pulses - c0), 64'd1);
        chk("abort_no_result", 64'(got.size()), 64'd0);

        // engine withholds ready on header word 2
        samp = '{16'h0010, 16'h0020, 16'h0020, 16'h0010};
        c0 = clr_pulses;
        d0 = done_pulses;
        start_run(4, 2, 2);
        wait_idle(400);
`ifdef SPM_SEQ_CHECK_EN
        chk("withhold_err", 64'(bus.err), 64'd1);
        chk("withhold_clr", 64'(clr_pulses - c0), 64'd1);
        chk("withhold_no_result", 64'(got.size()), 64'd0);
`else
        chk("withhold_err", 64'(bus.err), 64'd0);
        chk("withhold_done", 64'(done_pulses - d0), 64'd1);
        check_results(2);
`endif

        chk("protocol_violations", 64'(viol), 64'd0);
        $display("test done: total=%0d bad=%0d", total_chk, bad_chk);
        $finish;
    end

endmodule
